image_op_sequencer: RTL and testbench

//  Top-level scheduler for the image-processing engines (0=mirror, 1=gray, 2=sharpen filter).

---
 rtl/image_op_sequencer.sv | 133 +++++++++++++
 tb/tb_image_op_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/image_op_sequencer.sv
// Schedules the mirror/gray/filter engines in fixed order 0->1->2 and grants the
// shared image-memory port to whichever engine is running, with a per-op watchdog.
module image_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TO_W           = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_ops,
    output logic [2:0]  eng_start,
    input  logic [2:0]  eng_done,
    input  logic [17:0] eng_row,
    input  logic [17:0] eng_col,
    input  logic [2:0]  eng_we,
    input  logic [71:0] eng_pix,
    output logic [5:0]  row,
    output logic [5:0]  col,
    output logic        out_we,
    output logic [23:0] out_pix,
    output logic        busy,
    output logic        seq_done,
    output logic        timeout_err,
    output logic [1:0]  cur_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [2:0]      pending;
    logic [1:0]      idx;
    logic [TO_W-1:0] watchdog;
    logic            granted_done;
    logic            expired;

    function automatic logic [1:0] lowest_bit(input logic [2:0] mask);
        if (mask[0])      return 2'd0;
        else if (mask[1]) return 2'd1;
        else              return 2'd2;
    endfunction

    assign granted_done = eng_done[idx];
    assign expired      = (watchdog == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Done is tested before expiry so a finish on the last watchdog cycle still counts.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (cmd_valid) state_next = (cmd_ops == 3'b000) ? S_DONE : S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                if (granted_done) state_next = S_NEXT;
                else if (expired) state_next = S_IDLE;
            end
            S_NEXT:   state_next = (pending != 3'b000) ? S_LAUNCH : S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending     <= 3'b000;
            idx         <= 2'd0;
            watchdog    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        pending     <= cmd_ops;
                        idx         <= lowest_bit(cmd_ops);
                        timeout_err <= 1'b0;
                    end
                end
                S_LAUNCH: watchdog <= '0;
                S_WAIT: begin
                    if (!expired) watchdog <= watchdog + TO_W'(1);
                    if (granted_done) begin
                        pending[idx] <= 1'b0;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        pending     <= 3'b000;
                    end
                end
                S_NEXT:   idx <= lowest_bit(pending);
                default:  ;
            endcase
        end
    end

    // Handshake outputs are forced low while reset is held, whatever the state.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        eng_start = 3'b000;
        seq_done  = 1'b0;
        cur_op    = 2'd3;
        row       = 6'd0;
        col       = 6'd0;
        out_we    = 1'b0;
        out_pix   = 24'd0;
        if (!rst) begin
            cmd_ready = (state == S_IDLE);
            busy      = (state != S_IDLE);
            seq_done  = (state == S_DONE);
            if (state == S_LAUNCH) eng_start = 3'b001 << idx;
        end
        if (state == S_LAUNCH || state == S_WAIT) cur_op = idx;
        if (state == S_WAIT) begin
            row     = eng_row[6*idx +: 6];
            col     = eng_col[6*idx +: 6];
            out_we  = eng_we[idx];
            out_pix = eng_pix[24*idx +: 24];
        end
    end

endmodule

// File: tb/tb_image_op_sequencer.sv
// Randomized bench for image_op_sequencer: engine models with programmable done latency
// and a timeline reference model that predicts every cycle of a command.
module tb_image_op_sequencer;

    localparam int T    = 16;
    localparam int TLEN = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ops = 3'b000;
    logic [2:0]  eng_start;
    logic [2:0]  eng_done;
    logic [17:0] eng_row = '0;
    logic [17:0] eng_col = '0;
    logic [2:0]  eng_we = '0;
    logic [71:0] eng_pix = '0;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        out_we;
    logic [23:0] out_pix;
    logic        busy;
    logic        seq_done;
    logic        timeout_err;
    logic [1:0]  cur_op;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit exp_to_prev = 1'b0;

    int   delay [3];
    logic started [3];
    int   start_at [3];

    image_op_sequencer #(.TIMEOUT_CYCLES(T), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ops(cmd_ops),
        .eng_start(eng_start), .eng_done(eng_done), .eng_row(eng_row), .eng_col(eng_col),
        .eng_we(eng_we), .eng_pix(eng_pix), .row(row), .col(col), .out_we(out_we),
        .out_pix(out_pix), .busy(busy), .seq_done(seq_done), .timeout_err(timeout_err),
        .cur_op(cur_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine i raises done delay[i] cycles after its start pulse; delay 0 means never.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                started[i] <= 1'b0;
            end else if (eng_start[i]) begin
                started[i]  <= 1'b1;
                start_at[i] <= cyc;
            end
        end
    end

    always_comb begin
        eng_done = 3'b000;
        for (int i = 0; i < 3; i++)
            eng_done[i] = started[i] && (delay[i] > 0) && ((cyc - start_at[i]) >= delay[i]);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic driveEngines();
        eng_row = 18'($urandom);
        eng_col = 18'($urandom);
        eng_we  = 3'($urandom);
        eng_pix = {8'($urandom), 32'($urandom), 32'($urandom)};
    endtask

    task automatic checkPort(input int g);
        logic [17:0] r;
        logic [17:0] c;
        logic [71:0] p;
        r = eng_row;
        c = eng_col;
        p = eng_pix;
        if (g < 0) begin
            checkOutput("row", 32'(row), 32'd0);
            checkOutput("col", 32'(col), 32'd0);
            checkOutput("out_we", 32'(out_we), 32'd0);
            checkOutput("out_pix", 32'(out_pix), 32'd0);
        end else begin
            checkOutput("row", 32'(row), 32'(r[6*g +: 6]));
            checkOutput("col", 32'(col), 32'(c[6*g +: 6]));
            checkOutput("out_we", 32'(out_we), 32'(eng_we[g]));
            checkOutput("out_pix", 32'(out_pix), 32'(p[24*g +: 24]));
        end
    endtask

    // Builds the expected timeline from the op rules: each finished op costs LAUNCH + D WAIT
    // cycles + NEXT; an op not done within T WAIT cycles ends the command.
    task automatic applyStimulus(input logic [2:0] mask, input int d0, input int d1, input int d2,
                                 input bit hold);
        int  e_start [TLEN];
        bit  e_done [TLEN];
        int  e_cur [TLEN];
        int  e_grant [TLEN];
        int  d [3];
        int  t;
        int  last;
        bit  aborted;
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int k = 0; k < TLEN; k++) begin
            e_start[k] = 0; e_done[k] = 1'b0; e_cur[k] = 3; e_grant[k] = -1;
        end
        t = 0;
        last = 0;
        aborted = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (mask[i] && !aborted) begin
                e_start[t] = 1 << i;
                e_cur[t] = i;
                if (d[i] >= 1 && d[i] <= T) begin
                    for (int k = t + 1; k <= t + d[i]; k++) begin e_cur[k] = i; e_grant[k] = i; end
                    t = t + d[i] + 2;
                end else begin
                    for (int k = t + 1; k <= t + T; k++) begin e_cur[k] = i; e_grant[k] = i; end
                    last = t + T;
                    aborted = 1'b1;
                end
            end
        end
        if (!aborted) begin
            e_done[t] = 1'b1;
            last = t;
        end

        @(negedge clk);
        checkOutput("idle_ready", 32'(cmd_ready), 32'd1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("held_timeout", 32'(timeout_err), 32'(exp_to_prev));
        for (int i = 0; i < 3; i++) delay[i] = d[i];
        cmd_valid = 1'b1;
        cmd_ops = mask;
        driveEngines();
        for (int k = 0; k <= last + 1; k++) begin
            @(negedge clk);
            checkOutput("eng_start", 32'(eng_start), 32'(e_start[k]));
            checkOutput("seq_done", 32'(seq_done), 32'(e_done[k]));
            checkOutput("busy", 32'(busy), (k <= last) ? 32'd1 : 32'd0);
            checkOutput("cmd_ready", 32'(cmd_ready), (k <= last) ? 32'd0 : 32'd1);
            checkOutput("cur_op", 32'(cur_op), 32'(e_cur[k]));
            checkOutput("timeout_err", 32'(timeout_err), (aborted && k == last + 1) ? 32'd1 : 32'd0);
            checkPort(e_grant[k]);
            driveEngines();
            cmd_ops = 3'($urandom);
            cmd_valid = hold && (k <= last);
        end
        cmd_valid = 1'b0;
        exp_to_prev = aborted;
    endtask

    // Filter stalled in WAIT, then a one-cycle reset pulse.
    task automatic applyResetMidOp();
        @(negedge clk);
        delay[0] = 0; delay[1] = 0; delay[2] = 0;
        cmd_valid = 1'b1;
        cmd_ops = 3'b100;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_rst_cur_op", 32'(cur_op), 32'd2);
        rst = 1'b1;
        driveEngines();
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_start", 32'(eng_start), 32'd0);
        @(negedge clk);
        checkOutput("post_rst_cur_op", 32'(cur_op), 32'd3);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_done", 32'(seq_done), 32'd0);
        checkOutput("post_rst_timeout", 32'(timeout_err), 32'd0);
        checkPort(-1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post_rst_start", 32'(eng_start), 32'd0);
        exp_to_prev = 1'b0;
    endtask

    initial begin
        delay[0] = 0; delay[1] = 0; delay[2] = 0;
        driveEngines();
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_start", 32'(eng_start), 32'd0);
        checkOutput("reset_done", 32'(seq_done), 32'd0);
        checkOutput("reset_timeout", 32'(timeout_err), 32'd0);
        checkOutput("reset_cur_op", 32'(cur_op), 32'd3);
        checkPort(-1);
        rst = 1'b0;

        applyStimulus(3'b101, 10, 10, 10, 1'b0);
        applyStimulus(3'b000, 5, 5, 5, 1'b0);
        applyStimulus(3'b011, 0, 10, 10, 1'b0);
        applyStimulus(3'b110, 4, 6, 3, 1'b0);
        applyStimulus(3'b111, T, T, T, 1'b1);
        applyStimulus(3'b001, T + 1, 2, 2, 1'b1);
        applyResetMidOp();
        applyStimulus(3'b100, 1, 1, 1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int rd [3];
            for (int i = 0; i < 3; i++)
                rd[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
            applyStimulus(3'($urandom_range(0, 7)), rd[0], rd[1], rd[2], 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
